// File: rtl/button_pkg.sv
// button_pkg: shared state encoding and counter sizing for the button handler
package button_pkg;
  typedef enum logic [1:0] {RELEASED, CONFIRM_PRESS, HELD, CONFIRM_RELEASE} btn_state_t;
  function automatic int cnt_w(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/button_handler_n_if.sv
// button_handler_n_if: raw button levels in, debounced levels and event strobes out
interface button_handler_n_if #(parameter int N_BTN = 2);
  logic [N_BTN-1:0] button;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_long;
  modport master(output button, input btn_level, btn_press, btn_release, btn_long);
  modport slave(input button, output btn_level, btn_press, btn_release, btn_long);
endinterface

// File: rtl/button_channel.sv
// button_channel: one button: synchronizer, debounce FSM, long-press and auto-repeat timing
module button_channel
  import button_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 16,
  parameter int HOLD_CYC     = 1000,
  parameter int REPEAT_CYC   = 250,
  parameter int REPEAT_EN    = 1
) (
  input  logic clk,
  input  logic s_rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long
);
  localparam int W = cnt_w(DEBOUNCE_CYC, HOLD_CYC, REPEAT_CYC);
  localparam logic [W-1:0] DEB = W'(DEBOUNCE_CYC);
  localparam logic [W-1:0] HOLD = W'(HOLD_CYC);
  localparam logic [W-1:0] HOLD_M1 = W'(HOLD_CYC - 1);
  localparam logic [W-1:0] REP_M1 = W'(REPEAT_CYC - 1);
  localparam logic [W-1:0] ONE = W'(1);
  logic [SYNC_STAGES-1:0] r_sync;
  btn_state_t r_state, w_state_nxt;
  logic [W-1:0] r_deb, r_hold, r_rep, w_deb_nxt, w_hold_nxt, w_rep_nxt;
  logic w_s, w_press, w_release, w_long;
  assign w_s = r_sync[SYNC_STAGES-1];
  always_comb begin
    w_state_nxt = r_state;
    w_deb_nxt = r_deb;
    w_hold_nxt = r_hold;
    w_rep_nxt = r_rep;
    w_press = 1'b0;
    w_release = 1'b0;
    w_long = 1'b0;
    case (r_state)
      RELEASED: begin
        w_state_nxt = w_s ? CONFIRM_PRESS : RELEASED;
        w_deb_nxt = ONE;
      end
      CONFIRM_PRESS: begin
        if (!w_s) w_state_nxt = RELEASED;
        else if (r_deb == DEB) begin
          w_state_nxt = HELD;
          w_press = 1'b1;
          w_hold_nxt = '0;
          w_rep_nxt = '0;
        end else w_deb_nxt = r_deb + ONE;
      end
      HELD: begin
        // hold_cnt parks at HOLD; the repeat counter then carries the cadence forever
        if (r_hold != HOLD) begin
          w_hold_nxt = r_hold + ONE;
          w_long = (r_hold == HOLD_M1);
        end else if (REPEAT_EN != 0) begin
          w_press = (r_rep == REP_M1);
          w_rep_nxt = w_press ? '0 : r_rep + ONE;
        end
        if (!w_s) begin
          w_state_nxt = CONFIRM_RELEASE;
          w_deb_nxt = ONE;
        end
      end
      CONFIRM_RELEASE: begin
        if (w_s) w_state_nxt = HELD;
        else if (r_deb == DEB) begin
          w_state_nxt = RELEASED;
          w_release = 1'b1;
        end else w_deb_nxt = r_deb + ONE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (s_rst) begin
      r_sync <= '0;
      r_state <= RELEASED;
      r_deb <= '0;
      r_hold <= '0;
      r_rep <= '0;
      o_level <= 1'b0;
      o_press <= 1'b0;
      o_release <= 1'b0;
      o_long <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
      r_state <= w_state_nxt;
      r_deb <= w_deb_nxt;
      r_hold <= w_hold_nxt;
      r_rep <= w_rep_nxt;
      o_level <= (w_state_nxt == HELD) || (w_state_nxt == CONFIRM_RELEASE);
      o_press <= w_press;
      o_release <= w_release;
      o_long <= w_long;
    end
  end
endmodule

// File: rtl/button_handler_n.sv
// button_handler_n: N independent debounced button channels with long-press and auto-repeat
module button_handler_n
  import button_pkg::*;
#(
  parameter int N_BTN        = 2,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 16,
  parameter int HOLD_CYC     = 1000,
  parameter int REPEAT_CYC   = 250,
  parameter int REPEAT_EN    = 1
) (
  input logic clk,
  input logic s_rst,
  button_handler_n_if.slave bus
);
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    button_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .HOLD_CYC(HOLD_CYC),
      .REPEAT_CYC(REPEAT_CYC),
      .REPEAT_EN(REPEAT_EN)
    ) u_ch (
      .clk(clk),
      .s_rst(s_rst),
      .i_btn(bus.button[i]),
      .o_level(bus.btn_level[i]),
      .o_press(bus.btn_press[i]),
      .o_release(bus.btn_release[i]),
      .o_long(bus.btn_long[i])
    );
  end
endmodule

// File: tb/tb_button_handler_n.sv
// tb_button_handler_n: run-length reference model compared every cycle, plus directed latency checks
module tb_button_handler_n;
  localparam int DEB = 4, HOLD = 20, REP = 8, REN = 1;
  logic clk = 1'b0;
  logic s_rst = 1'b1;
  int checks = 0, errors = 0;
  button_handler_n_if #(.N_BTN(2)) bus ();
  button_handler_n #(
    .N_BTN(2), .SYNC_STAGES(2), .DEBOUNCE_CYC(DEB),
    .HOLD_CYC(HOLD), .REPEAT_CYC(REP), .REPEAT_EN(REN)
  ) dut (.clk(clk), .s_rst(s_rst), .bus(bus));
  always #5 clk = ~clk;
  logic [1:0] smp_btn = '0;
  logic smp_rst = 1'b1;
  always @(posedge clk) begin
    smp_btn <= bus.button;
    smp_rst <= s_rst;
  end
  bit armed = 1'b0;
  bit m_lvl[2];
  int m_run[2], m_held[2];
  bit [1:0] m_hist[2];
  logic [1:0] e_lvl = '0, e_press = '0, e_rel = '0, e_long = '0;
  // level flips once the synchronized input has disagreed with it DEB+1 samples in a row;
  // held time only advances on edges where the level is 1 and no low run is pending
  task automatic model_step(input logic [1:0] b, input logic rst);
    if (rst) begin
      armed = 1'b1;
      e_lvl = '0; e_press = '0; e_rel = '0; e_long = '0;
      for (int c = 0; c < 2; c++) begin
        m_lvl[c] = 1'b0; m_run[c] = 0; m_held[c] = 0; m_hist[c] = '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        bit s;
        s = m_hist[c][1];
        m_hist[c] = {m_hist[c][0], b[c]};
        e_press[c] = 1'b0; e_rel[c] = 1'b0; e_long[c] = 1'b0;
        if (m_lvl[c] && m_run[c] == 0) begin
          m_held[c]++;
          e_long[c] = (m_held[c] == HOLD);
          e_press[c] = (REN != 0) && m_held[c] > HOLD && ((m_held[c] - HOLD) % REP == 0);
        end
        m_run[c] = (s != m_lvl[c]) ? m_run[c] + 1 : 0;
        if (m_run[c] == DEB + 1) begin
          m_lvl[c] = !m_lvl[c];
          m_run[c] = 0;
          m_held[c] = 0;
          e_press[c] = m_lvl[c];
          e_rel[c] = !m_lvl[c];
        end
        e_lvl[c] = m_lvl[c];
      end
    end
  endtask
  task automatic cmp(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t act=%b exp=%b", name, $time, act, exp);
    end
  endtask
  initial forever begin
    @(negedge clk);
    model_step(smp_btn, smp_rst);
    if (armed) begin
      cmp("level", bus.btn_level, e_lvl);
      cmp("press", bus.btn_press, e_press);
      cmp("release", bus.btn_release, e_rel);
      cmp("long", bus.btn_long, e_long);
    end
  end
  for (genvar i = 0; i < 2; i++) begin : g_sva
    assert property (@(posedge clk) disable iff (!armed)
      $onehot0({bus.btn_press[i], bus.btn_release[i], bus.btn_long[i]}))
      else begin errors++; $display("FAIL sva_exclusive ch%0d t=%0t", i, $time); end
    assert property (@(posedge clk) disable iff (!armed) bus.btn_press[i] |=> !bus.btn_press[i])
      else begin errors++; $display("FAIL sva_press_width ch%0d t=%0t", i, $time); end
    assert property (@(posedge clk) disable iff (!armed) bus.btn_release[i] |=> !bus.btn_release[i])
      else begin errors++; $display("FAIL sva_release_width ch%0d t=%0t", i, $time); end
    assert property (@(posedge clk) disable iff (!armed) bus.btn_long[i] |=> !bus.btn_long[i])
      else begin errors++; $display("FAIL sva_long_width ch%0d t=%0t", i, $time); end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask
  // steps until the chosen strobe (0 press, 1 long, 2 release) fires on ch; -1 if it never does
  task automatic wait_for(input int kind, input int ch, output int n);
    logic [1:0] v;
    n = -1;
    for (int i = 1; i <= 64; i++) begin
      step();
      v = (kind == 0) ? bus.btn_press : (kind == 1) ? bus.btn_long : bus.btn_release;
      if (v[ch]) begin
        n = i;
        break;
      end
    end
  endtask
  initial begin
    int n, seen;
    bus.button = '0;
    step();
    step();
    s_rst = 1'b0;
    chk("reset_outs", int'({bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_long}), 0);
    bus.button[0] = 1'b1;
    repeat (3) step();
    bus.button[0] = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      seen |= int'({bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_long});
    end
    chk("short_glitch_none", seen, 0);
    bus.button[0] = 1'b1;
    wait_for(0, 0, n);
    chk("press_latency", n, 7);
    chk("level_on", int'(bus.btn_level[0]), 1);
    step();
    chk("press_one_cycle", int'(bus.btn_press[0]), 0);
    bus.button[0] = 1'b0;
    wait_for(2, 0, n);
    chk("release_latency", n, 7);
    chk("level_off", int'(bus.btn_level[0]), 0);
    repeat (4) step();
    bus.button[0] = 1'b1;
    wait_for(0, 0, n);
    chk("hold_press", n, 7);
    wait_for(1, 0, n);
    chk("long_after_press", n, HOLD);
    for (int r = 0; r < 3; r++) begin
      wait_for(0, 0, n);
      chk("repeat_period", n, REP);
    end
    bus.button[0] = 1'b0;
    wait_for(2, 0, n);
    chk("hold_release", n, 7);
    repeat (4) step();
    bus.button[0] = 1'b1;
    wait_for(0, 0, n);
    chk("glitch_press", n, 7);
    wait_for(1, 0, n);
    chk("glitch_long", n, HOLD);
    wait_for(0, 0, n);
    chk("glitch_rep1", n, REP);
    bus.button[0] = 1'b0;
    step();
    step();
    bus.button[0] = 1'b1;
    // two edges spent in CONFIRM_RELEASE pause the repeat timer, pushing this one 2 later
    wait_for(0, 0, n);
    chk("glitch_rep_resume", n, 8);
    chk("glitch_level_held", int'(bus.btn_level[0]), 1);
    wait_for(0, 0, n);
    chk("glitch_rep_next", n, REP);
    bus.button[0] = 1'b0;
    wait_for(2, 0, n);
    chk("glitch_release", n, 7);
    repeat (4) step();
    bus.button = 2'b11;
    wait_for(0, 0, n);
    chk("dual_press_lat", n, 7);
    chk("dual_press_both", int'(bus.btn_press), 3);
    bus.button = 2'b00;
    wait_for(2, 0, n);
    chk("dual_release_lat", n, 7);
    chk("dual_release_both", int'(bus.btn_release), 3);
    repeat (4) step();
    bus.button = 2'b01;
    wait_for(0, 0, n);
    chk("rst_pre_press", n, 7);
    repeat (5) step();
    s_rst = 1'b1;
    step();
    s_rst = 1'b0;
    chk("midhold_reset_outs", int'({bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_long}), 0);
    wait_for(0, 0, n);
    chk("repress_after_reset", n, 7);
    bus.button = 2'b00;
    wait_for(2, 0, n);
    chk("final_release", n, 7);
    repeat (4) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
